// File: rtl/answer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : answer_pkg
//  Brief    : Shared types and helpers for the answer judge: FSM state
//             encoding, nibble width and a digit extraction function.
//  Revision : 1.0  initial release
// ============================================================================
package answer_pkg;

    localparam int NIBBLE = 4;

    // Digit index wide enough for the largest legal DIGITS (8)
    typedef logic [2:0] idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READY   = 2'd1,
        COMPARE = 2'd2,
        OVER    = 2'd3
    } state_t;

    // Return nibble i of a 32-bit word (digit i = word[4i+3:4i])
    function automatic logic [NIBBLE-1:0] digit(input logic [31:0] word, input idx_t i);
        return word[i*NIBBLE +: NIBBLE];
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : digit_scorer
//  Brief    : Combinational scoring of one guess digit at position k against
//             the whole answer: strike on same position, otherwise ball when
//             the value appears anywhere else in the answer.
//  Revision : 1.0  initial release
// ============================================================================
module digit_scorer
    import answer_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic [NIBBLE-1:0]        guess_digit,
    input  logic [NIBBLE*DIGITS-1:0] answer,
    input  logic [KW-1:0]            k,
    output logic                     is_strike,
    output logic                     is_ball
);

    logic [DIGITS-1:0] w_match;
    logic [31:0]       w_answer_word;

    assign w_answer_word = 32'(answer);

    // One equality comparator per answer position
    generate
        for (genvar j = 0; j < DIGITS; j++) begin : g_match
            assign w_match[j] = (digit(w_answer_word, idx_t'(j)) == guess_digit);
        end
    endgenerate

    // Without a strike, w_match[k] is clear, so any remaining match is at j != k
    assign is_strike = w_match[k];
    assign is_ball   = !is_strike && (|w_match);

endmodule
`default_nettype wire

// File: rtl/answer_judge.sv
`default_nettype none
// ============================================================================
//  Module   : answer_judge
//  Brief    : Latches the generator's answer word, accepts guesses over a
//             valid/ready handshake, scores them one digit per cycle into
//             strikes/balls and tracks the attempt budget (win / lose).
//  Revision : 1.0  initial release
// ============================================================================
module answer_judge
    import answer_pkg::*;
#(
    parameter  int DIGITS    = 4,
    parameter  int MAX_TRIES = 10,
    localparam int CW        = $clog2(DIGITS + 1),
    localparam int TW        = $clog2(MAX_TRIES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              rand_word,
    input  logic                     write_enable,
    input  logic                     guess_valid,
    input  logic [NIBBLE*DIGITS-1:0] guess,
    output logic                     guess_ready,
    output logic                     result_valid,
    output logic [CW-1:0]            strikes,
    output logic [CW-1:0]            balls,
    output logic [TW-1:0]            tries_left,
    output logic                     win,
    output logic                     lose,
    output logic                     busy
);

    localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GW = NIBBLE * DIGITS;

    state_t              r_state;
    state_t              w_next_state;
    logic [GW-1:0]       r_answer;
    logic [GW-1:0]       r_guess;
    logic [KW-1:0]       r_k;
    logic [CW-1:0]       r_acc_s;
    logic [CW-1:0]       r_acc_b;
    logic [CW-1:0]       r_strikes;
    logic [CW-1:0]       r_balls;
    logic [TW-1:0]       r_tries;
    logic                r_win;
    logic                r_lose;
    logic                r_result_valid;

    logic [NIBBLE-1:0]   w_guess_digit;
    logic                w_is_strike;
    logic                w_is_ball;
    logic                w_last;
    logic                w_win;
    logic                w_out_of_tries;
    logic                w_accept;
    logic [CW-1:0]       w_sum_s;
    logic [CW-1:0]       w_sum_b;
    logic                w_unused_rand;

    // Only the low DIGITS nibbles of the generator word form the answer
    assign w_unused_rand  = ^rand_word;

    assign w_guess_digit  = digit(32'(r_guess), idx_t'(r_k));
    assign w_last         = (r_k == KW'(DIGITS - 1));
    assign w_sum_s        = r_acc_s + CW'(w_is_strike);
    assign w_sum_b        = r_acc_b + CW'(w_is_ball);
    assign w_win          = (w_sum_s == CW'(DIGITS));
    assign w_out_of_tries = (r_tries == TW'(1));
    assign w_accept       = (r_state == READY) && guess_valid;

    digit_scorer #(
        .DIGITS (DIGITS)
    ) u_scorer (
        .guess_digit (w_guess_digit),
        .answer      (r_answer),
        .k           (r_k),
        .is_strike   (w_is_strike),
        .is_ball     (w_is_ball)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a new answer overrides everything, including a live compare
    always_comb begin
        w_next_state = r_state;
        if (write_enable) begin
            w_next_state = READY;
        end else begin
            case (r_state)
                READY: begin
                    if (guess_valid) begin
                        w_next_state = COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_last) begin
                        w_next_state = (w_win || w_out_of_tries) ? OVER : READY;
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    // Datapath: answer capture, guess capture, digit-serial accumulation, results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_answer       <= '0;
            r_guess        <= '0;
            r_k            <= '0;
            r_acc_s        <= '0;
            r_acc_b        <= '0;
            r_strikes      <= '0;
            r_balls        <= '0;
            r_tries        <= '0;
            r_win          <= 1'b0;
            r_lose         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (write_enable) begin
                r_answer  <= rand_word[GW-1:0];
                r_tries   <= TW'(MAX_TRIES);
                r_win     <= 1'b0;
                r_lose    <= 1'b0;
                r_strikes <= '0;
                r_balls   <= '0;
                r_acc_s   <= '0;
                r_acc_b   <= '0;
                r_k       <= '0;
            end else if (w_accept) begin
                r_guess <= guess;
                r_acc_s <= '0;
                r_acc_b <= '0;
                r_k     <= '0;
            end else if (r_state == COMPARE) begin
                if (w_last) begin
                    // OVER is entered at zero, so this decrement never wraps
                    r_strikes      <= w_sum_s;
                    r_balls        <= w_sum_b;
                    r_result_valid <= 1'b1;
                    r_tries        <= r_tries - TW'(1);
                    r_win          <= w_win;
                    r_lose         <= !w_win && w_out_of_tries;
                end else begin
                    r_acc_s <= w_sum_s;
                    r_acc_b <= w_sum_b;
                    r_k     <= r_k + KW'(1);
                end
            end
        end
    end

    assign guess_ready  = (r_state == READY);
    assign busy         = (r_state == COMPARE);
    assign result_valid = r_result_valid;
    assign strikes      = r_strikes;
    assign balls        = r_balls;
    assign tries_left   = r_tries;
    assign win          = r_win;
    assign lose         = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_answer_judge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_answer_judge
//  Brief    : Directed self-checking bench for answer_judge (DIGITS=4,
//             MAX_TRIES=10) with hand-computed expected scores.
//  Revision : 1.0  initial release
// ============================================================================
module tb_answer_judge;

    localparam int DIGITS    = 4;
    localparam int MAX_TRIES = 10;
    localparam int CW        = 3;
    localparam int TW        = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     rand_word;
    logic            write_enable;
    logic            guess_valid;
    logic [15:0]     guess;
    logic            guess_ready;
    logic            result_valid;
    logic [CW-1:0]   strikes;
    logic [CW-1:0]   balls;
    logic [TW-1:0]   tries_left;
    logic            win;
    logic            lose;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;

    answer_judge #(
        .DIGITS    (DIGITS),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rand_word    (rand_word),
        .write_enable (write_enable),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .guess_ready  (guess_ready),
        .result_valid (result_valid),
        .strikes      (strikes),
        .balls        (balls),
        .tries_left   (tries_left),
        .win          (win),
        .lose         (lose),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] w);
        rand_word    = w;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    // Offer a guess, complete the handshake, wait (bounded) for result_valid
    task automatic play(input string tag, input logic [15:0] g, output int lat);
        bit seen;
        guess       = g;
        guess_valid = 1'b1;
        check({tag, "_ready"}, guess_ready, 1);
        tick();
        guess_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (result_valid) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        check({tag, "_result_seen"}, seen, 1);
    endtask

    initial begin
        int lat;
        int rv_cnt;

        rst          = 1'b1;
        rand_word    = '0;
        write_enable = 1'b0;
        guess_valid  = 1'b0;
        guess        = '0;
        tick();
        check("rst_tries", tries_left, 0);
        check("rst_ready", guess_ready, 0);
        check("rst_win",   win, 0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_ready", guess_ready, 0);

        // 1. load and win on the first guess
        load(32'h0000_4321);
        check("t1_tries10", tries_left, 10);
        check("t1_ready",   guess_ready, 1);
        play("t1", 16'h4321, lat);
        check("t1_latency", lat, 5);
        check("t1_strikes", strikes, 4);
        check("t1_balls",   balls, 0);
        check("t1_win",     win, 1);
        check("t1_tries",   tries_left, 9);
        check("t1_ready_after", guess_ready, 0);
        tick();
        check("t1_rv_pulse", result_valid, 0);
        tick();
        check("t1_ready_hold", guess_ready, 0);
        check("t1_win_hold",   win, 1);

        // 2. scoring with the same answer
        load(32'h0000_4321);
        check("t2_win_clr", win, 0);
        check("t2_str_clr", strikes, 0);
        play("t2a", 16'h1234, lat);
        check("t2a_strikes", strikes, 0);
        check("t2a_balls",   balls, 4);
        check("t2a_tries",   tries_left, 9);
        play("t2b", 16'h4312, lat);
        check("t2b_strikes", strikes, 2);
        check("t2b_balls",   balls, 2);
        check("t2b_tries",   tries_left, 8);
        play("t2c", 16'h5678, lat);
        check("t2c_strikes", strikes, 0);
        check("t2c_balls",   balls, 0);
        check("t2c_tries",   tries_left, 7);
        tick();
        check("t2_hold_tries", tries_left, 7);
        check("t2_hold_rv",    result_valid, 0);

        // 3. repeated digits
        load(32'h0000_1111);
        play("t3a", 16'h1221, lat);
        check("t3a_strikes", strikes, 2);
        check("t3a_balls",   balls, 0);
        load(32'h0000_1234);
        play("t3b", 16'h1111, lat);
        check("t3b_strikes", strikes, 1);
        check("t3b_balls",   balls, 3);

        // 4. exhaustion
        load(32'h0000_1234);
        for (int n = 1; n <= MAX_TRIES; n++) begin
            play("t4", 16'h5678, lat);
            check("t4_tries", tries_left, MAX_TRIES - n);
            check("t4_lose",  lose, (n == MAX_TRIES) ? 1 : 0);
        end
        check("t4_ready", guess_ready, 0);
        check("t4_win",   win, 0);
        tick();
        check("t4_lose_hold", lose, 1);
        load(32'h0000_1234);
        check("t4_reload_tries", tries_left, 10);
        check("t4_reload_lose",  lose, 0);
        check("t4_reload_ready", guess_ready, 1);

        // 5. abort a compare with a new answer
        guess       = 16'h8888;
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        tick();
        check("t5_busy", busy, 1);
        rand_word    = 32'h0000_8888;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        check("t5_ready", guess_ready, 1);
        rv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (result_valid) rv_cnt++;
            tick();
        end
        check("t5_no_result", rv_cnt, 0);
        check("t5_tries",     tries_left, 10);
        play("t5", 16'h8888, lat);
        check("t5_strikes", strikes, 4);
        check("t5_win",     win, 1);

        // 6. asynchronous reset mid-compare, then guesses ignored in IDLE
        load(32'h0000_1234);
        guess       = 16'h5678;
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        tick();
        check("t6_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_busy0",  busy, 0);
        check("t6_tries0", tries_left, 0);
        check("t6_str0",   strikes, 0);
        check("t6_ready0", guess_ready, 0);
        check("t6_rv0",    result_valid, 0);
        check("t6_lose0",  lose, 0);
        tick();
        rst = 1'b0;
        guess       = 16'h1234;
        guess_valid = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_idle_ready", guess_ready, 0);
            if (result_valid || busy) rv_cnt++;
        end
        guess_valid = 1'b0;
        check("t6_idle_quiet", rv_cnt, 0);
        check("t6_idle_tries", tries_left, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/answer_judge.md
Name: answer_judge

Overview:
Downstream consumer of the 32-bit random answer word and its one-cycle write_enable strobe from the game's random generator. Latches the low DIGITS nibbles as the secret answer and accepts player guesses over a valid/ready handshake. Scores each guess digit-serially into strikes and balls, and tracks the attempt budget to flag win or lose. Results go to the display/UI stage.

Parameters:
DIGITS, 4, number of answer/guess digits (nibbles); legal range 1..8
MAX_TRIES, 10, guesses allowed per answer; legal range 1..15
CW, $clog2(DIGITS+1), width of the strike and ball counts (localparam)
TW, $clog2(MAX_TRIES+1), width of the tries counter (localparam)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
rand  in  32  answer word from the generator; digit i = rand[4i+3:4i]
write_enable  in  1  one-cycle strobe: capture rand as the new answer
guess_valid  in  1  guess offered
guess  in  4*DIGITS  guess digits; digit i = guess[4i+3:4i]
guess_ready  out  1  high only in READY
result_valid  out  1  one-cycle pulse: strikes/balls valid
strikes  out  CW  count of digits matching value and position
balls  out  CW  count of digits matching value in a different position
tries_left  out  TW  remaining guesses
win  out  1  level; answer guessed
lose  out  1  level; budget exhausted without a win
busy  out  1  high in COMPARE

Behaviour:
- Async reset: state=IDLE. answer=0, strikes=0, balls=0, tries_left=0, and all 1-bit outputs=0.
- States: IDLE (no answer), READY, COMPARE, OVER.
- write_enable in any state, including mid-COMPARE:
  - capture answer from rand; tries_left=MAX_TRIES; win=lose=0; strikes=balls=0.
  - go to READY next cycle.
  - abort any COMPARE in progress; the aborted guess produces no result_valid.
  - write_enable has priority over a same-cycle guess handshake; that guess is dropped.
- READY, on guess_valid&&guess_ready (cycle T):
  - register guess; clear the internal strike and ball accumulators; digit index k=0; go to COMPARE.
- COMPARE: one cycle per digit k=0..DIGITS-1.
  - strike if g[k]==a[k].
  - else ball if g[k]==a[j] for any j!=k.
  - each guess digit adds at most 1 to either count. Repeated answer digits are legal (generator may repeat); no dedup is done on the answer side.
  - values 0 and 9..15 score normally; the generator yields 1..8, so these never match a generated answer.
- At the cycle after the last digit (T+DIGITS+1):
  - result_valid=1 for exactly one cycle; strikes/balls updated; tries_left decremented by 1.
  - strikes==DIGITS: win=1, go to OVER.
  - else if tries_left reaches 0: lose=1, go to OVER.
  - else go back to READY; the next guess can be accepted on the following cycle.
- strikes/balls/tries_left hold their values between results.
- OVER: guess_ready=0; win/lose hold until the next write_enable or reset.
- IDLE: guess_ready=0 until the first write_enable.
- tries_left never underflows. The decrement happens only on result_valid, and OVER is entered at 0.
- Accumulator width is CW; the maximum DIGITS cannot overflow it.

Decomposition:
- Shared package answer_pkg holds:
  - the state enum (IDLE, READY, COMPARE, OVER);
  - the NIBBLE width constant 4;
  - the function digit(word, i).
- One sub-module, digit_scorer: combinational. Inputs are the guess digit, the answer vector and index k. Outputs are is_strike and is_ball. The FSM, counters and handshake stay in answer_judge.

Test Plan:
1. Load: rand=0x0000_4321 with write_enable. Guess 0x4321 -> result_valid at T+5; strikes=4, balls=0, win=1, tries_left=9; guess_ready stays 0 afterwards.
2. Scoring with the same answer:
   - guess 0x1234 -> strikes=0, balls=4
   - guess 0x4312 -> strikes=2, balls=2
   - guess 0x5678 -> 0, 0
   - tries_left goes 9, 8, 7
3. Repeats: rand=0x0000_1111, guess 0x1221 -> strikes=2, balls=0. Then rand=0x0000_1234, guess 0x1111 -> strikes=1, balls=3.
4. Exhaustion: 10 consecutive guesses of 0x5678 -> the 10th result gives tries_left=0, lose=1, guess_ready=0. Then write_enable -> READY, tries_left=10, lose=0.
5. Abort: write_enable asserted at T+2 of a COMPARE with rand=0x0000_8888 -> no result_valid for that guess. The next guess 0x8888 returns strikes=4.
6. Reset: assert rst mid-COMPARE -> immediately IDLE, all outputs 0. A guess_valid while in IDLE is ignored (guess_ready=0).
